ringosc_freq_meter: RTL
=======================

# ringosc_freq_meter

Measurement controller that sits directly downstream of the ring-oscillator ripple counter. It owns that counter's `cnt_reset`/`cnt_stop` controls and runs a window of exactly N `clk` cycles. It then freezes the oscillator and brings the asynchronous counter value safely into the `clk` domain. A sample is accepted only after consecutive identical synchronized readings, and the 64-bit result is presented as a latched word plus a byte-select readout.

## Interface
- `CNT_W`, 64: counter width.
- `WIN_W`, 24: window-length width.
- `CLR_CYCLES`, 4: cycles `cnt_reset` is held high per measurement.
- `SETTLE_CYCLES`, 8: cycles after oscillator stop before sampling begins.
- `MATCH_N`, 2: consecutive matching samples required for acceptance.
- `TIMEOUT`, 64: maximum number of SAMPLE cycles before an error is flagged.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a measurement when sampled high in IDLE.
- `abort`  in  1  cancel the measurement in progress.
- `win_len`  in  WIN_W  window length in `clk` cycles, captured at start; 0 is treated as 1.
- `cnt_in`  in  CNT_W  raw ripple-counter bits, asynchronous to `clk`.
- `byte_sel`  in  3  result byte select.
- `cnt_reset`  out  1  counter clear, active-high.
- `cnt_stop`  out  1  oscillator stop, active-high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a measurement.
- `valid`  out  1  level; `result` is a trusted count.
- `err`  out  1  level; sampling timed out.
- `result`  out  CNT_W  latched count.
- `byte_out`  out  8  `result[8*byte_sel +: 8]`, registered.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `cnt_stop`=1, `cnt_reset`=0, `busy`=`done`=`valid`=`err`=0, `result`=0, `byte_out`=0.
- A synchronizer runs continuously: `cnt_in` -> `s1` -> `s2`, both CNT_W wide. `prev` <= `s2` every cycle.
- FSM states and transitions:
  - **IDLE**: `cnt_stop`=1, `cnt_reset`=0. `start` with `abort` low moves to CLEAR. On that transition, `win_len` is latched and `valid`/`err` are cleared.
  - **CLEAR**: `cnt_reset`=1, `cnt_stop`=1 for CLR_CYCLES cycles, then RUN.
  - **RUN**: `cnt_reset`=0, `cnt_stop`=0 for exactly max(win_len,1) cycles, then HOLD.
  - **HOLD**: `cnt_stop`=1 for SETTLE_CYCLES cycles, then SAMPLE. The match counter and timeout counter are cleared on entry.
  - **SAMPLE**: each cycle, if `s2`==`prev` the match counter increments; otherwise it returns to 0.
    - On reaching MATCH_N: `result`<=`s2`, `valid`<=1, `done`<=1, go to IDLE.
    - If TIMEOUT SAMPLE cycles elapse without acceptance: `result`<=`s2`, `err`<=1, `valid` stays 0, `done`<=1, go to IDLE.
- `abort` in any non-IDLE state: next edge goes to IDLE with `cnt_stop`=1 and `cnt_reset`=0. `done` is not pulsed, `valid`=0, and `result` is unchanged.
- Simultaneous events:
  - `start` while busy: ignored.
  - `start` and `abort` in the same cycle in IDLE: `abort` wins and no measurement starts.
  - `start` in the cycle `done` is high: state is already IDLE, so it is accepted.
- `rst` mid-operation: all outputs return to their reset values on the next edge, including `cnt_reset`=0 and `cnt_stop`=1.
- Window counter arithmetic: counts down from max(win_len,1) in WIN_W bits. It does not wrap, because the maximum window is 2^WIN_W−1.
- `byte_out` updates every cycle from the current `result` and `byte_sel`.

## Timing
- Take `start` sampled at edge 0.
  - Edges 1..CLR_CYCLES: `cnt_reset`=1.
  - Next max(win_len,1) edges: `cnt_stop`=0.
  - Then SETTLE_CYCLES edges of HOLD.
  - Then SAMPLE.
- With a counter already stable, `done` is high at edge CLR_CYCLES + W + SETTLE_CYCLES + MATCH_N + 1, where W = max(win_len,1). With default parameters this is W+15.
- `busy` rises at edge 1 and falls on the same edge `done` rises.
- `done` is exactly one cycle wide.
- `byte_out` latency from `byte_sel` or `result` change: 1 cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-RUN -> next edge `cnt_stop`=1, `cnt_reset`=0, `busy`/`done`/`valid`/`err`=0, `result`=0.
- **Nominal measurement:** behavioural counter adds 3 per `clk` while `cnt_stop`=0 and clears on `cnt_reset`; `win_len`=100 -> `done` at edge 115, `result`=300, `valid`=1, `err`=0.
- **Minimum window:** `win_len`=0 -> `cnt_stop` low for exactly 1 cycle, `done` at edge 16. A second `start` at edge 5 is ignored.
- **Noisy counter:** `cnt_in` toggles bit 0 every cycle during SAMPLE -> `done` at edge 4+10+8+64+1=87, `err`=1, `valid`=0.
- **Abort:** `abort` at edge 50 of a `win_len`=100 run -> IDLE at edge 51, `cnt_stop`=1, no `done` pulse, `valid`=0, `result` unchanged.
- **Byte readout:** force `result`=0x0123456789ABCDEF; `byte_sel`=7 -> `byte_out`=0x01 one cycle later; `byte_sel`=0 -> 0xEF one cycle later.

Source files
------------

// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter: clears and gates the ripple counter for a fixed
// window, then synchronizes and debounces its frozen value into a latched result.
module ringosc_freq_meter #(
    parameter int CNT_W         = 64,
    parameter int WIN_W         = 24,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int MATCH_N       = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic [2:0]       byte_sel,
    output logic             cnt_reset,
    output logic             cnt_stop,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             err,
    output logic [CNT_W-1:0] result,
    output logic [7:0]       byte_out
);

    localparam int PH_MAX0 = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int PH_MAX  = (PH_MAX0 > TIMEOUT) ? PH_MAX0 : TIMEOUT;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int MATCH_W = $clog2(MATCH_N + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, HOLD, SAMPLE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   s1, s2, prev;
    logic [WIN_W-1:0]   wcnt;
    logic [PH_W-1:0]    ph;
    logic [MATCH_W-1:0] mcnt;
    logic               same;

    // Free-running two-flop synchronizer plus one-cycle history for the match test.
    always_ff @(posedge clk) begin
        s1   <= cnt_in;
        s2   <= s1;
        prev <= s2;
    end

    assign same = (s2 == prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt_stop  <= 1'b1;
            cnt_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            wcnt      <= '0;
            ph        <= '0;
            mcnt      <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                cnt_stop  <= 1'b1;
                cnt_reset <= 1'b0;
                busy      <= 1'b0;
                valid     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_stop  <= 1'b1;
                        cnt_reset <= 1'b0;
                        if (start && !abort) begin
                            state     <= CLEAR;
                            busy      <= 1'b1;
                            cnt_reset <= 1'b1;
                            valid     <= 1'b0;
                            err       <= 1'b0;
                            ph        <= '0;
                            wcnt      <= (win_len == '0) ? WIN_W'(1) : win_len;
                        end
                    end
                    CLEAR: begin
                        if (ph == PH_W'(CLR_CYCLES - 1)) begin
                            state     <= RUN;
                            cnt_reset <= 1'b0;
                            cnt_stop  <= 1'b0;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                    RUN: begin
                        if (wcnt == WIN_W'(1)) begin
                            state    <= HOLD;
                            cnt_stop <= 1'b1;
                            ph       <= '0;
                            mcnt     <= '0;
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (ph == PH_W'(SETTLE_CYCLES - 1)) begin
                            state <= SAMPLE;
                            ph    <= '0;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        // ph counts SAMPLE cycles here and doubles as the timeout counter.
                        if (same && mcnt == MATCH_W'(MATCH_N - 1)) begin
                            state  <= IDLE;
                            result <= s2;
                            valid  <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                        end else if (ph == PH_W'(TIMEOUT - 1)) begin
                            state  <= IDLE;
                            result <= s2;
                            err    <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            ph   <= ph + 1'b1;
                            mcnt <= same ? mcnt + 1'b1 : '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) byte_out <= '0;
        else     byte_out <= result[8*byte_sel +: 8];
    end

endmodule
